serial_parity_rx: RTL
=====================

Name: serial_parity_rx

Overview:
- Serial frame receiver that checks parity on incoming frames; it is the receiving end of the team's XOR-based parity generator and serial transmit path.
- Frame format: 1 start bit (0), DATA_W data bits LSB first, 1 parity bit, 1 stop bit (1).
- Bits are presented one per i_bit_en strobe. Bit-timing recovery is done upstream.
- Delivers the parallel word plus parity and framing error flags to downstream logic.

Parameters:
- DATA_W, 8, number of data bits per frame (legal range 1 to 16).

Ports:
- i_clk  input  1  system clock, rising edge active.
- i_rst_n  input  1  asynchronous active-low reset.
- i_bit_en  input  1  strobe: sample i_rx on this clock edge.
- i_rx  input  1  serial line, idle high.
- o_data  output  DATA_W  last received data word.
- o_valid  output  1  one-cycle pulse when a frame completes.
- o_parity_err  output  1  parity mismatch on the last frame.
- o_frame_err  output  1  stop bit was 0 on the last frame.
- o_busy  output  1  high while a frame is in progress or the line is in break.

Behaviour:
- Clocking and reset:
  - One clock, i_clk.
  - Reset i_rst_n is asynchronous and active-low.
  - While i_rst_n=0: state=IDLE, o_data=0, o_valid=0, o_parity_err=0, o_frame_err=0, o_busy=0, bit counter=0, parity accumulator=0.
- All outputs are registered.
- The state advances only on edges where i_bit_en=1. When i_bit_en=0, the state, counter and accumulator hold.
- o_valid is always cleared on the next edge after it pulses, regardless of i_bit_en.
- States:
  - IDLE:
    - i_bit_en=1 and i_rx=0: go to DATA, set counter=0 and acc=0.
    - i_rx=1: stay in IDLE.
  - DATA:
    - On each strobe, shift i_rx into the shift register LSB-first and update acc ^= i_rx.
    - After DATA_W strobes (counter wraps from DATA_W-1), go to PARITY.
  - PARITY: on the strobe, capture the parity bit and go to STOP.
  - STOP: on the strobe, at that same edge:
    - o_data <= shift register.
    - o_valid <= 1.
    - o_parity_err <= acc ^ pbit (even parity: error when the XOR is 1).
    - o_frame_err <= ~i_rx.
    - Next state: IDLE if i_rx=1, otherwise BREAK.
  - BREAK:
    - Waits for a strobe with i_rx=1, then goes to IDLE.
    - A low line in BREAK is never taken as a start bit.
- Latency: o_valid is high for exactly the one cycle following the edge that samples the stop bit.
- o_data, o_parity_err and o_frame_err update only on o_valid and hold until the next o_valid.
- o_valid pulses for every completed frame, including frames with errors.
- o_busy = (state != IDLE), registered alongside the state.
- No start-bit revalidation: a single strobed 0 in IDLE starts a frame.
- Reset asserted mid-frame:
  - The frame is dropped immediately and no o_valid is produced.
  - After reset is released, reception resumes in IDLE.
- A strobe arriving on the same edge as o_valid clearing is processed normally.
- Back-to-back frames are supported: a start bit may arrive on the strobe immediately after the stop strobe.

Optional Feature:
- Macro: SERIAL_PARITY_RX_ODD_EN.
- When defined: the block checks odd parity, o_parity_err <= ~(acc ^ pbit).
- When undefined (default): the block checks even parity as described in Behaviour.
- Ports and timing are identical in both builds.

Test Plan:
- Good frame, DATA_W=8, even build:
  - Stimulus: strobe bits 0, then 1,0,1,0,0,1,0,1 (0xA5), parity 0, stop 1.
  - Response: o_valid is a single-cycle pulse; o_data=0xA5, o_parity_err=0, o_frame_err=0; o_busy returns to 0.
- Parity error:
  - Stimulus: frame 0x07 with parity bit 0.
  - Response: o_valid pulses; o_data=0x07, o_parity_err=1, o_frame_err=0.
- Frame error and break:
  - Stimulus: frame 0x3C, parity 0, stop 0.
  - Response: o_frame_err=1 and o_busy stays 1.
  - Then: two strobes with i_rx=0 start no frame; a strobe with i_rx=1 followed by a valid 0x55 frame gives o_data=0x55 with both error flags 0.
- Strobe gaps and idle glitches:
  - Stimulus: i_rx=0 for 3 cycles without i_bit_en while in IDLE; then a 0xA5 frame with random gaps of 0 to 5 cycles between strobes.
  - Response: the glitch produces no activity; the frame decodes to 0xA5 with no errors.
- Reset mid-frame:
  - Stimulus: assert i_rst_n=0 after 4 data bits.
  - Response: all outputs go to 0 asynchronously and no o_valid is produced.
  - Then: a following 0x3C frame is received correctly; back-to-back 0x3C then 0xC3 frames give two o_valid pulses.
- Odd build (SERIAL_PARITY_RX_ODD_EN defined):
  - Stimulus: 0xA5 with parity 1.
  - Response: o_parity_err=0. The same frame with parity 0 gives o_parity_err=1.

Source files
------------

// File: rtl/serial_parity_rx_if.sv
// Serial parity receiver bus: strobed serial input plus the decoded word and error flags.
// The master modport is the upstream/consumer side; the slave modport is the receiver.
interface serial_parity_rx_if #(
  parameter int DATA_W = 8
);
  logic              i_bit_en;
  logic              i_rx;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              o_parity_err;
  logic              o_frame_err;
  logic              o_busy;

  modport master (
    output i_bit_en, i_rx,
    input  o_data, o_valid, o_parity_err, o_frame_err, o_busy
  );

  modport slave (
    input  i_bit_en, i_rx,
    output o_data, o_valid, o_parity_err, o_frame_err, o_busy
  );
endinterface

// File: rtl/serial_parity_rx.sv
// Strobed serial frame receiver: start(0), DATA_W data bits LSB first, parity, stop(1).
// Define SERIAL_PARITY_RX_ODD_EN to check odd parity instead of even.
module serial_parity_rx #(
  parameter int DATA_W = 8
) (
  input logic               i_clk,
  input logic               i_rst_n,
  serial_parity_rx_if.slave bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

`ifdef SERIAL_PARITY_RX_ODD_EN
  localparam logic PAR_INV = 1'b1;
`else
  localparam logic PAR_INV = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, BRK} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              acc;
  logic              pbit;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shift_nxt;

  // Right shift with the new bit entering at the MSB, so the first data bit lands in bit 0.
  always_comb begin
    shift_nxt             = shreg >> 1;
    shift_nxt[DATA_W-1]   = bus.i_rx;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      acc              <= 1'b0;
      pbit             <= 1'b0;
      shreg            <= '0;
      bus.o_data       <= '0;
      bus.o_valid      <= 1'b0;
      bus.o_parity_err <= 1'b0;
      bus.o_frame_err  <= 1'b0;
      bus.o_busy       <= 1'b0;
    end else begin
      bus.o_valid <= 1'b0;
      if (bus.i_bit_en) begin
        unique case (state)
          IDLE: begin
            if (!bus.i_rx) begin
              state      <= DATA;
              cnt        <= '0;
              acc        <= 1'b0;
              bus.o_busy <= 1'b1;
            end
          end
          DATA: begin
            shreg <= shift_nxt;
            acc   <= acc ^ bus.i_rx;
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= PARITY;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PARITY: begin
            pbit  <= bus.i_rx;
            state <= STOP;
          end
          STOP: begin
            bus.o_data       <= shreg;
            bus.o_valid      <= 1'b1;
            bus.o_parity_err <= acc ^ pbit ^ PAR_INV;
            bus.o_frame_err  <= ~bus.i_rx;
            // A low stop bit means the line is in break; wait for it to go high.
            state            <= bus.i_rx ? IDLE : BRK;
            bus.o_busy       <= ~bus.i_rx;
          end
          BRK: begin
            if (bus.i_rx) begin
              state      <= IDLE;
              bus.o_busy <= 1'b0;
            end
          end
          default: begin
            state      <= IDLE;
            bus.o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
